// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_W   : default divisor / quotient / remainder width (dividend is 2*DIV_W)
//   CNT_W   : width of the per-bit iteration counter
//   SAT_VAL : quotient/remainder value reported for divide-by-zero and overflow
//   state_t : controller states
package div_pkg;

    localparam int DIV_W = 8;
    localparam int CNT_W = $clog2(DIV_W);

    localparam logic [DIV_W-1:0] SAT_VAL = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/div_step8.sv
// One combinational restoring-division step.
// Ports:
//   i_rem  : partial remainder entering the step (always < i_b)
//   i_bit  : next dividend bit shifted into the remainder
//   i_b    : divisor
//   o_rem  : partial remainder leaving the step
//   o_qbit : quotient bit produced by the step
module div_step8
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    // The trial value needs one extra bit: {rem, bit} can reach 2*B-1.
    logic [W:0] w_t;

    // NOTE: every signal is assigned on every pass through the block, so no latch is inferred.
    always_comb begin
        w_t    = {i_rem, i_bit};
        o_qbit = (w_t >= {1'b0, i_b});
        // The difference is below B whenever it is taken, so its top bit is always zero.
        o_rem  = o_qbit ? W'(w_t - {1'b0, i_b}) : w_t[W-1:0];
    end

endmodule

// File: rtl/divider16by8_seq.sv
// Sequential 2W-by-W unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (in_ready high only while idle)
//   P, B                 : dividend (2W bits) and divisor (W bits), sampled on accept
//   out_valid / out_ready: result handshake; Q/R/ovf/dz held while out_valid is high
//   Q, R                 : quotient and remainder (all ones on error)
//   ovf                  : quotient would not fit in W bits
//   dz                   : divisor was zero
module divider16by8_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] P,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   R,
    output logic           ovf,
    output logic           dz
);

    localparam int           CW  = (W == DIV_W) ? CNT_W : $clog2(W);
    localparam logic [W-1:0] SAT = (W == DIV_W) ? W'(SAT_VAL) : {W{1'b1}};

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_qsh;   // remaining dividend bits shift out the top, quotient bits in the bottom
    logic [W-1:0]    r_q;
    logic [W-1:0]    r_r;
    logic            r_ovf;
    logic            r_dz;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [W-1:0]    w_rem_nxt;
    logic            w_qbit;
    logic [W-1:0]    w_qsh_nxt;

    div_step8 #(.W(W)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_qsh[W-1]),
        .i_b    (r_b),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    assign w_qsh_nxt = {r_qsh[W-2:0], w_qbit};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, because Q/R/ovf/dz must read zero after reset.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_qsh       <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_b        <= B;
                        r_in_ready <= 1'b0;
                        if (B == '0) begin
                            r_dz        <= 1'b1;
                            r_ovf       <= 1'b0;
                            r_q         <= SAT;
                            r_r         <= SAT;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (P[2*W-1:W] >= B) begin
                            // Upper half >= B means the quotient needs more than W bits.
                            r_dz        <= 1'b0;
                            r_ovf       <= 1'b1;
                            r_q         <= SAT;
                            r_r         <= SAT;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_dz    <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_rem   <= P[2*W-1:W];
                            r_qsh   <= P[W-1:0];
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_qsh <= w_qsh_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W-1)) begin
                        r_q         <= w_qsh_nxt;
                        r_r         <= w_rem_nxt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Q         = r_q;
    assign R         = r_r;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

endmodule

// File: tb/tb_divider16by8_seq.sv
// Self-checking bench for divider16by8_seq: directed cases, error cases,
// backpressure, mid-run reset, throughput and randomized traffic against an
// arithmetic reference model.
module tb_divider16by8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] P;
    logic [7:0]  B;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        ovf;
    logic        dz;

    int n_checks = 0;
    int n_errors = 0;

    divider16by8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    // The two handshake-side flags must never be high together.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ((in_ready & out_valid) !== 1'b0) begin
                n_errors++;
                $display("FAIL ready_valid_exclusive: in_ready=%b out_valid=%b at %0t", in_ready, out_valid, $time);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer division with the error predicates.
    function automatic void ref_div(input logic [15:0] p, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic ov, output logic z);
        int quo;
        if (b == 8'd0) begin
            z = 1'b1; ov = 1'b0; q = 8'hFF; r = 8'hFF;
        end else begin
            quo = int'(p) / int'(b);
            z = 1'b0;
            if (quo > 255) begin
                ov = 1'b1; q = 8'hFF; r = 8'hFF;
            end else begin
                ov = 1'b0;
                q  = quo[7:0];
                r  = 8'(int'(p) % int'(b));
            end
        end
    endfunction

    // Present one request and return at the first negedge where out_valid is high.
    // lat counts rising edges from (and including) the accepting edge.
    task automatic run_op(input logic [15:0] p, input logic [7:0] b, input bit rand_ready,
                          output int lat, output bit ok);
        int guard;
        ok = 1'b0;
        lat = 0;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_in_ready: in_ready=%b required 1 within 50 cycles", in_ready);
            return;
        end
        P = p;
        B = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            // Inputs are ignored once accepted; scramble them to prove it.
            P = 16'($urandom);
            B = 8'($urandom);
            if (out_valid === 1'b1) begin
                out_ready = 1'b0;
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL result_timeout: out_valid not seen within 50 cycles (P=%h B=%h)", p, b);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        P = '0;
        B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, Q, R, ovf, dz} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b Q=%h R=%h ovf=%b dz=%b required 1 0 00 00 0 0",
                     in_ready, out_valid, Q, R, ovf, dz);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] tp [2];
        logic [7:0]  tb_ [2];
        logic [7:0]  tq [2];
        logic [7:0]  tr [2];
        int lat;
        bit ok;
        tp[0] = 16'h1234; tb_[0] = 8'h56; tq[0] = 8'h36; tr[0] = 8'h10;
        tp[1] = 16'hFE01; tb_[1] = 8'hFF; tq[1] = 8'hFF; tr[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            run_op(tp[i], tb_[i], 1'b0, lat, ok);
            if (!ok) return;
            n_checks++;
            if ({Q, R, ovf, dz} !== {tq[i], tr[i], 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL directed_result[%0d]: Q=%h R=%h ovf=%b dz=%b required %h %h 0 0",
                         i, Q, R, ovf, dz, tq[i], tr[i]);
            end
            n_checks++;
            if (lat !== 9) begin
                n_errors++;
                $display("FAIL directed_latency[%0d]: got %0d required 9", i, lat);
            end
            release_out();
            n_checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_errors++;
                $display("FAIL directed_return_idle[%0d]: in_ready=%b out_valid=%b required 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_errors();
        int lat;
        bit ok;
        run_op(16'h5600, 8'h56, 1'b0, lat, ok);
        if (!ok) return;
        n_checks++;
        if ({Q, R, ovf, dz, lat} !== {8'hFF, 8'hFF, 1'b1, 1'b0, 32'd1}) begin
            n_errors++;
            $display("FAIL overflow: Q=%h R=%h ovf=%b dz=%b lat=%0d required FF FF 1 0 lat 1",
                     Q, R, ovf, dz, lat);
        end
        release_out();
        run_op(16'h1234, 8'h00, 1'b0, lat, ok);
        if (!ok) return;
        n_checks++;
        if ({Q, R, ovf, dz, lat} !== {8'hFF, 8'hFF, 1'b0, 1'b1, 32'd1}) begin
            n_errors++;
            $display("FAIL divide_by_zero: Q=%h R=%h ovf=%b dz=%b lat=%0d required FF FF 0 1 lat 1",
                     Q, R, ovf, dz, lat);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        run_op(16'h1234, 8'h56, 1'b0, lat, ok);
        if (!ok) return;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({Q, R, out_valid, in_ready} !== {8'h36, 8'h10, 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL backpressure_hold[%0d]: Q=%h R=%h out_valid=%b in_ready=%b required 36 10 1 0",
                         c, Q, R, out_valid, in_ready);
            end
        end
        release_out();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit ok;
        P = 16'h1234;
        B = 8'h56;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, Q, R} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
            n_errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b Q=%h R=%h required 1 0 00 00",
                     in_ready, out_valid, Q, R);
        end
        run_op(16'h00FF, 8'h10, 1'b0, lat, ok);
        if (!ok) return;
        n_checks++;
        if ({Q, R, ovf, dz, lat} !== {8'h0F, 8'h0F, 1'b0, 1'b0, 32'd9}) begin
            n_errors++;
            $display("FAIL after_reset_op: Q=%h R=%h ovf=%b dz=%b lat=%0d required 0F 0F 0 0 lat 9",
                     Q, R, ovf, dz, lat);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        first = -1;
        second = -1;
        P = 16'h1234;
        B = 8'h56;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (in_ready === 1'b1) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (second >= 0) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (second - first !== 10) begin
            n_errors++;
            $display("FAIL throughput: accept spacing %0d cycles required 10 (first=%0d second=%0d)",
                     second - first, first, second);
        end
        // Drain whatever is left in flight.
        out_ready = 1'b1;
        for (int c = 0; c < 20 && in_ready !== 1'b1; c++) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] p;
        logic [7:0]  b;
        logic [7:0]  eq;
        logic [7:0]  er;
        logic        eov;
        logic        ez;
        int lat;
        bit ok;
        for (int n = 0; n < 2000; n++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 31) == 0) b = 8'h00;
            p = 16'($urandom);
            if (b != 8'h00 && $urandom_range(0, 3) != 0) p[15:8] = 8'($urandom_range(0, int'(b) - 1));
            ref_div(p, b, eq, er, eov, ez);
            run_op(p, b, 1'b1, lat, ok);
            if (!ok) return;
            n_checks++;
            if ({Q, R, ovf, dz} !== {eq, er, eov, ez}) begin
                n_errors++;
                $display("FAIL random_result[%0d]: P=%h B=%h got Q=%h R=%h ovf=%b dz=%b required %h %h %b %b",
                         n, p, b, Q, R, ovf, dz, eq, er, eov, ez);
            end
            n_checks++;
            if (lat !== ((eov || ez) ? 1 : 9)) begin
                n_errors++;
                $display("FAIL random_latency[%0d]: got %0d required %0d", n, lat, (eov || ez) ? 1 : 9);
            end
            if (!eov && !ez) begin
                n_checks++;
                if ((int'(Q) * int'(b) + int'(R) != int'(p)) || (R >= b)) begin
                    n_errors++;
                    $display("FAIL random_identity[%0d]: Q*B+R=%0d P=%0d R=%h B=%h",
                             n, int'(Q) * int'(b) + int'(R), p, R, b);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
